// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package serial_add_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_add_seq_mfadd.sv
// 4-bit ripple-carry adder; the single shared datapath stage of the sequencer.
module mfadd
  import serial_add_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           ci,
  output logic [NIB-1:0] s,
  output logic           c0
);

  // Ripple the carry bit by bit through the nibble.
  always_comb begin : ripple
    logic c;
    c  = ci;
    s  = '0;
    for (int i = 0; i < NIB; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c0 = c;
  end

endmodule

// File: rtl/serial_add_seq.sv
// Nibble-serial WIDTH-bit adder: time-shares one 4-bit adder, LSB nibble first,
// with valid/ready handshakes on both the operand and the result side.
module serial_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c0
);
  import serial_add_pkg::*;

  localparam int unsigned NSTEP = WIDTH / NIB;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if ((WIDTH % NIB) != 0 || WIDTH < 8) begin : g_width_check
    $error("serial_add_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-NIB-1:0] sum_sh;   // nibbles already produced, newest at the top
  logic                 carry;
  logic [CW-1:0]        count;
  logic [NIB-1:0]       add_s;
  logic                 add_c;
  logic [WIDTH-1:0]     sum_nx;

  mfadd u_mfadd (
    .a  (a_sh[NIB-1:0]),
    .b  (b_sh[NIB-1:0]),
    .ci (carry),
    .s  (add_s),
    .c0 (add_c)
  );

  // Partial sum including the nibble the adder is producing this cycle.
  assign sum_nx = {add_s, sum_sh};

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      c0        <= 1'b0;
      carry     <= 1'b0;
      count     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= ci;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          carry  <= add_c;
          sum_sh <= sum_nx[WIDTH-1:NIB];
          a_sh   <= a_sh >> NIB;
          b_sh   <= b_sh >> NIB;
          if (count == CW'(NSTEP - 1)) begin
            s         <= sum_nx;
            c0        <= add_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=16 with a cycle model, WIDTH=8 spot checks).
module tb_serial_add_seq;

  localparam int unsigned W      = 16;
  localparam int unsigned W8     = 8;
  localparam int unsigned NSTEP  = W / 4;
  localparam int unsigned NSTEP8 = W8 / 4;
  localparam int          TMO    = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          ci = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          c0;
  logic [W-1:0]  s;

  logic          in_valid8 = 1'b0;
  logic          out_ready8 = 1'b0;
  logic          ci8 = 1'b0;
  logic [W8-1:0] a8 = '0;
  logic [W8-1:0] b8 = '0;
  logic          in_ready8;
  logic          out_valid8;
  logic          c08;
  logic [W8-1:0] s8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c0(c0)
  );

  serial_add_seq #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c0(c08)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: an accepted op yields a+b+ci, visible NSTEP cycles later,
  // held until taken; a new op may be offered only the cycle after the take.
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  logic         m_c0    = 1'b0;
  logic [W-1:0] m_s     = '0;
  logic [W:0]   m_res   = '0;
  int           m_left  = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ready = 1'b1; m_valid = 1'b0; m_s = '0; m_c0 = 1'b0; m_left = 0;
    end else if (m_ready && in_valid) begin
      m_res   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      m_left  = NSTEP;
      m_ready = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        {m_c0, m_s} = m_res;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
  end

  // Every-cycle comparison of the 16-bit DUT against the model.
  always @(negedge clk) begin
    if (chk_en)
      check("model", 32'({in_ready, out_valid, c0, s}), 32'({m_ready, m_valid, m_c0, m_s}));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                        input logic [W-1:0] es, input logic ec, input int hold,
                        input logic bp_valid, input string tag);
    int n;
    logic [W:0] g;
    g = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tci};
    n = 0;
    while (in_ready !== 1'b1 && n < TMO) begin step(); n++; end
    check($sformatf("%s ready_wait", tag), 32'(n < TMO), 32'(1));
    a = ta; b = tb_; ci = tci; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < TMO) begin step(); n++; end
    check($sformatf("%s latency", tag), 32'(n), 32'(NSTEP));
    check($sformatf("%s sum", tag), 32'({c0, s}), 32'({ec, es}));
    check($sformatf("%s golden", tag), 32'({c0, s}), 32'(g));
    in_valid = bp_valid;
    for (int i = 0; i < hold; i++) begin
      step();
      check($sformatf("%s hold", tag), 32'({in_ready, out_valid, c0, s}),
            32'({1'b0, 1'b1, ec, es}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("%s release", tag), 32'({out_valid, c0, s}), 32'({1'b0, ec, es}));
  endtask

  task automatic run_op8(input logic [W8-1:0] ta, input logic [W8-1:0] tb_, input logic tci,
                         input logic [W8-1:0] es, input logic ec, input string tag);
    int n;
    logic [W8:0] g;
    g = {1'b0, ta} + {1'b0, tb_} + {{W8{1'b0}}, tci};
    n = 0;
    while (in_ready8 !== 1'b1 && n < TMO) begin step(); n++; end
    check($sformatf("%s ready_wait", tag), 32'(n < TMO), 32'(1));
    a8 = ta; b8 = tb_; ci8 = tci; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom);
    n = 0;
    while (out_valid8 !== 1'b1 && n < TMO) begin step(); n++; end
    check($sformatf("%s latency", tag), 32'(n), 32'(NSTEP8));
    check($sformatf("%s sum", tag), 32'({c08, s8}), 32'({ec, es}));
    check($sformatf("%s golden", tag), 32'({c08, s8}), 32'(g));
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    check($sformatf("%s release", tag), 32'({out_valid8, in_ready8}), 32'({1'b0, 1'b1}));
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (!(in_ready === 1'b1 && out_valid === 1'b0) && n < TMO) begin step(); n++; end
    check("drain", 32'(n < TMO), 32'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    int acc[$];
    rst = 1'b1;
    repeat (2) step();
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset16", 32'({in_ready, out_valid, c0, s}), 32'({1'b1, 1'b0, 1'b0, 16'h0000}));
    check("reset8", 32'({in_ready8, out_valid8, c08, s8}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));

    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0, 1'b0, "t1");
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0, "t2");
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0, 1'b0, "t3");
    run_op(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 5, 1'b1, "t4");

    // Reset two cycles into RUN aborts the op and clears the held result.
    a = 16'h9999; b = 16'h9999; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5 after reset", 32'({in_ready, out_valid, c0, s}), 32'({1'b1, 1'b0, 1'b0, 16'h0000}));
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b0, "t5");

    // Back-to-back with both handshakes tied high.
    a = 16'h7FFF; b = 16'h0001; ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && acc.size() < 4; k++) begin
      if (in_ready === 1'b1) acc.push_back(cyc);
      if (out_valid === 1'b1) check("t6 sum", 32'({c0, s}), 32'({1'b0, 16'h8000}));
      step();
    end
    check("t6 accepts", 32'(acc.size()), 32'(4));
    for (int i = 1; i < acc.size(); i++)
      check("t6 interval", 32'(acc[i] - acc[i-1]), 32'(6));
    drain();

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      ci        = 1'($urandom);
      out_ready = (($urandom % 3) != 0);
      step();
    end
    drain();

    run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "w8 t1");
    run_op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "w8 t3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
